// File: rtl/key_schedule_seq.sv
// key_schedule_seq: sequential C/D key-half rotator. It produces NROUNDS
// shifted {C,D} round keys (before PC-2) over a valid/ready handshake. The
// encrypt schedule rotates left and the decrypt schedule rotates right.
module key_schedule_seq #(
  parameter int                 HALF_W      = 28,
  parameter int                 NROUNDS     = 16,
  parameter logic [NROUNDS-1:0] SHIFT1_MASK = NROUNDS'(16'h8103),
  localparam int                RW          = $clog2(NROUNDS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                decrypt,
  input  logic                abort,
  input  logic [2*HALF_W-1:0] key_in,
  output logic [2*HALF_W-1:0] rk_out,
  output logic [RW-1:0]       rk_round,
  output logic                rk_valid,
  input  logic                rk_ready,
  output logic                busy,
  output logic                done
);

  localparam int KW = 2 * HALF_W;

  // A zero is padded on top so that a round index of RW bits fully addresses the mask.
  localparam logic [NROUNDS:0] MASK_X = {1'b0, SHIFT1_MASK};
  localparam logic [RW-1:0]    LAST   = RW'(NROUNDS);
  localparam logic [RW-1:0]    ONE    = RW'(1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e          state_q, state_d;
  logic            mode_q, mode_d;
  logic [KW-1:0]   rk_out_q, rk_out_d;
  logic [RW-1:0]   rk_round_q, rk_round_d;
  logic            rk_valid_q, rk_valid_d;
  logic            done_q, done_d;

  logic            xfer;
  logic            last_round;
  logic [RW-1:0]   enc_idx;
  logic [RW-1:0]   dec_idx;

  // Rotate one key half by one position (one=1) or by two positions (one=0).
  function automatic logic [HALF_W-1:0] rot_half(input logic [HALF_W-1:0] x,
                                                 input logic left, input logic one);
    if (left) return one ? {x[HALF_W-2:0], x[HALF_W-1]}
                         : {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]};
    else      return one ? {x[0], x[HALF_W-1:1]}
                         : {x[1:0], x[HALF_W-1:2]};
  endfunction

  // C and D rotate by the same amount, and each half rotates only within itself.
  function automatic logic [KW-1:0] rot_cd(input logic [KW-1:0] cd,
                                           input logic left, input logic one);
    return {rot_half(cd[KW-1:HALF_W], left, one), rot_half(cd[HALF_W-1:0], left, one)};
  endfunction

  assign xfer       = rk_valid_q && rk_ready;
  assign last_round = (rk_round_q == LAST);
  // The next encrypt round r+1 uses mask bit r. The next decrypt round uses s(NROUNDS+1-r).
  assign enc_idx    = rk_round_q;
  assign dec_idx    = LAST - rk_round_q;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so that every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: abort has priority over start and over the final transfer.
  // NOTE: each always_comb output gets a default first so that no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && !abort)             state_d = RUN;
      RUN:     if (abort || (xfer && last_round)) state_d = IDLE;
      default:                                  state_d = IDLE;
    endcase
  end

  // Output and datapath next values. These are registered below.
  always_comb begin
    mode_d     = mode_q;
    rk_out_d   = rk_out_q;
    rk_round_d = rk_round_q;
    rk_valid_d = rk_valid_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        rk_valid_d = 1'b0;
        if (start && !abort) begin
          mode_d     = decrypt;
          rk_round_d = ONE;
          rk_valid_d = 1'b1;
          rk_out_d   = decrypt ? key_in : rot_cd(key_in, 1'b1, MASK_X[0]);
        end
      end
      RUN: begin
        if (abort) begin
          rk_valid_d = 1'b0;
        end else if (xfer) begin
          if (last_round) begin
            rk_valid_d = 1'b0;
            done_d     = 1'b1;
          end else begin
            rk_round_d = rk_round_q + ONE;
            rk_out_d   = mode_q ? rot_cd(rk_out_q, 1'b0, MASK_X[dec_idx])
                                : rot_cd(rk_out_q, 1'b1, MASK_X[enc_idx]);
          end
        end
      end
      default: rk_valid_d = 1'b0;
    endcase
  end

  // Output and datapath registers.
  // NOTE: every register here, including the key datapath, is reset, so outputs read 0 during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= 1'b0;
      rk_out_q   <= '0;
      rk_round_q <= '0;
      rk_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      rk_out_q   <= rk_out_d;
      rk_round_q <= rk_round_d;
      rk_valid_q <= rk_valid_d;
      done_q     <= done_d;
    end
  end

  assign rk_out   = rk_out_q;
  assign rk_round = rk_round_q;
  assign rk_valid = rk_valid_q;
  assign done     = done_q;
  assign busy     = (state_q == RUN);

endmodule

// File: tb/tb_key_schedule_seq.sv
// Testbench for key_schedule_seq. It uses directed vectors and randomized
// backpressure runs, and checks them against a cumulative-rotation reference model.
module tb_key_schedule_seq;

  localparam int HW = 28;
  localparam int NR = 16;
  localparam int RW = 5;
  localparam int KW = 2 * HW;
  localparam logic [NR-1:0] MASK = 16'h8103;
  localparam logic [KW-1:0] KEY0 = {28'hF0CCAAF, 28'h556678F};

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, decrypt, abort, rk_ready;
  logic [KW-1:0] key_in, rk_out;
  logic [RW-1:0] rk_round;
  logic          rk_valid, busy, done;

  int n_pass  = 0;
  int n_total = 0;

  logic [KW-1:0] got     [NR+1];
  logic [KW-1:0] enc_got [NR+1];

  always #5 clk = ~clk;

  key_schedule_seq #(.HALF_W(HW), .NROUNDS(NR), .SHIFT1_MASK(MASK)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .decrypt(decrypt), .abort(abort),
    .key_in(key_in), .rk_out(rk_out), .rk_round(rk_round), .rk_valid(rk_valid),
    .rk_ready(rk_ready), .busy(busy), .done(done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic int shift_of(input int r);
    return (((MASK >> (r - 1)) & 16'd1) != 16'd0) ? 1 : 2;
  endfunction

  function automatic logic [HW-1:0] rotl(input logic [HW-1:0] x, input int n);
    logic [2*HW-1:0] d;
    d = {x, x} << (n % HW);
    return d[2*HW-1:HW];
  endfunction

  // Round r equals the key rotated by the total of all shifts applied so far.
  function automatic logic [KW-1:0] exp_key(input logic dec, input logic [KW-1:0] key, input int r);
    int amt;
    amt = 0;
    if (!dec) begin
      for (int i = 1; i <= r; i++) amt += shift_of(i);
    end else begin
      for (int k = 1; k < r; k++) amt += shift_of(NR + 1 - k);
      amt = HW - (amt % HW);
    end
    return {rotl(key[KW-1:HW], amt), rotl(key[HW-1:0], amt)};
  endfunction

  // Start a run and follow it to done. rk_ready is high with probability ready_pct %.
  // When called from the done cycle, this also tests a back-to-back start.
  task automatic do_run(input logic dec, input logic [KW-1:0] key, input int ready_pct,
                        input string tag);
    int            exp_r;
    int            cycles;
    logic          stalled;
    logic [KW-1:0] last_out;
    logic [RW-1:0] last_round;
    start    = 1'b1;
    decrypt  = dec;
    key_in   = key;
    abort    = 1'b0;
    rk_ready = ($urandom_range(99) < ready_pct);
    step();
    start    = 1'b0;
    decrypt  = ~dec;
    key_in   = ~key;
    exp_r    = 1;
    cycles   = 0;
    stalled  = 1'b0;
    last_out = '0;
    last_round = '0;
    while (exp_r <= NR) begin
      if (cycles > 4000) begin
        n_total++;
        $display("FAIL %s timeout: stuck at round %0d, expected progress to %0d", tag, rk_round, NR);
        break;
      end
      check({tag, " valid"}, 64'(rk_valid), 64'd1);
      check({tag, " busy"}, 64'(busy), 64'd1);
      if (rk_valid !== 1'b1) break;
      if (stalled) begin
        check({tag, " stall out"}, 64'(rk_out), 64'(last_out));
        check({tag, " stall round"}, 64'(rk_round), 64'(last_round));
      end
      check({tag, " round"}, 64'(rk_round), 64'(exp_r));
      check({tag, " key"}, 64'(rk_out), 64'(exp_key(dec, key, exp_r)));
      got[exp_r] = rk_out;
      last_out   = rk_out;
      last_round = rk_round;
      rk_ready   = ($urandom_range(99) < ready_pct);
      start      = 1'($urandom_range(1));
      stalled    = !rk_ready;
      if (rk_ready) exp_r++;
      step();
      cycles++;
    end
    start = 1'b0;
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " end valid"}, 64'(rk_valid), 64'd0);
    check({tag, " end busy"}, 64'(busy), 64'd0);
    check({tag, " end round"}, 64'(rk_round), 64'(NR));
    check({tag, " end out"}, 64'(rk_out), 64'(last_out));
  endtask

  typedef struct {
    string         name;
    logic          dec;
    logic [KW-1:0] key;
    int            round;
    logic [KW-1:0] exp;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int cycles;
    tbl[0] = '{"enc r1",  1'b0, KEY0, 1,  {28'hE19955F, 28'hAACCF1E}};
    tbl[1] = '{"enc r16", 1'b0, KEY0, 16, KEY0};
    tbl[2] = '{"dec r1",  1'b1, KEY0, 1,  KEY0};
    tbl[3] = '{"dec r2",  1'b1, KEY0, 2,  {28'hF866557, 28'hAAB33C7}};
    tbl[4] = '{"dec r16", 1'b1, KEY0, 16, {28'hE19955F, 28'hAACCF1E}};

    rst_n = 1'b0; start = 1'b0; decrypt = 1'b0; abort = 1'b0; rk_ready = 1'b0; key_in = '0;
    #2;
    check("reset out", 64'(rk_out), 64'd0);
    check("reset round", 64'(rk_round), 64'd0);
    check("reset valid", 64'(rk_valid), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    step();
    rst_n = 1'b1;

    // Directed vectors. Runs follow each other back to back from the done cycle.
    for (int i = 0; i < 5; i++) begin
      do_run(tbl[i].dec, tbl[i].key, 100, tbl[i].name);
      check(tbl[i].name, 64'(got[tbl[i].round]), 64'(tbl[i].exp));
    end
    step();
    check("done one cycle", 64'(done), 64'd0);

    // Decrypt round r must match encrypt round NR+1-r.
    do_run(1'b0, KEY0, 100, "mirror enc");
    for (int r = 1; r <= NR; r++) enc_got[r] = got[r];
    do_run(1'b1, KEY0, 100, "mirror dec");
    for (int r = 1; r <= NR; r++)
      check("mirror", 64'(got[r]), 64'(enc_got[NR + 1 - r]));
    step();

    // Randomized keys, modes and backpressure.
    for (int n = 0; n < 6; n++) begin
      do_run(1'($urandom_range(1)), {$urandom(), $urandom()} >> 8, 55, "random");
      repeat ($urandom_range(2)) step();
    end

    // Abort at round 7 while a transfer is in progress.
    start = 1'b1; decrypt = 1'b0; key_in = KEY0; rk_ready = 1'b1;
    step();
    start = 1'b0;
    cycles = 0;
    while (rk_round != RW'(7) && cycles < 50) begin step(); cycles++; end
    check("abort at round", 64'(rk_round), 64'd7);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort valid", 64'(rk_valid), 64'd0);
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    repeat (3) begin step(); check("abort no done", 64'(done), 64'd0); end
    do_run(1'b0, KEY0, 100, "after abort");
    step();

    // Reset at round 5 forces the outputs low asynchronously.
    start = 1'b1; decrypt = 1'b1; key_in = KEY0; rk_ready = 1'b1;
    step();
    start = 1'b0;
    cycles = 0;
    while (rk_round != RW'(5) && cycles < 50) begin step(); cycles++; end
    check("pre-reset round", 64'(rk_round), 64'd5);
    #1 rst_n = 1'b0;
    #1;
    check("mid reset out", 64'(rk_out), 64'd0);
    check("mid reset round", 64'(rk_round), 64'd0);
    check("mid reset valid", 64'(rk_valid), 64'd0);
    check("mid reset busy", 64'(busy), 64'd0);
    check("mid reset done", 64'(done), 64'd0);
    #1 rst_n = 1'b1;

    // When start and abort are both high in IDLE, no run starts.
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("start+abort busy", 64'(busy), 64'd0);
    check("start+abort valid", 64'(rk_valid), 64'd0);
    check("start+abort done", 64'(done), 64'd0);
    do_run(1'b1, KEY0, 70, "after reset");
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/key_schedule_seq.md
KEY_SCHEDULE_SEQ -- requirements
Module: key_schedule_seq

Interface
REQ-001 Parameter HALF_W, default 28, width of each key half (C and D); legal range 3..64.
REQ-002 Parameter NROUNDS, default 16, number of round keys produced per run; legal range 2..255.
REQ-003 Parameter SHIFT1_MASK, NROUNDS bits, default 16'h8103; bit r-1 set means round r uses a shift of 1, clear means a shift of 2 (default gives rounds 1, 2, 9 and 16 a shift of 1).
REQ-004 Local RW = clog2(NROUNDS+1), the width of the round index.
REQ-005 Port clk, input, 1, the single clock; all logic is rising-edge.
REQ-006 Port rst_n, input, 1, asynchronous active-low reset.
REQ-007 Port start, input, 1, request to begin a run; sampled only in IDLE.
REQ-008 Port decrypt, input, 1, mode sampled with start; 0 = left-shift (encrypt) schedule, 1 = right-shift (decrypt) schedule.
REQ-009 Port abort, input, 1, synchronous cancel of a run.
REQ-010 Port key_in, input, 2*HALF_W, CD0 value; C = key_in[2*HALF_W-1:HALF_W], D = key_in[HALF_W-1:0].
REQ-011 Port rk_out, output, 2*HALF_W, current shifted {C,D} (pre-PC-2).
REQ-012 Port rk_round, output, RW, 1-based index of the key on rk_out.
REQ-013 Port rk_valid, output, 1, rk_out/rk_round hold a valid key.
REQ-014 Port rk_ready, input, 1, the consumer accepts the key; a transfer occurs when rk_valid && rk_ready.
REQ-015 Port busy, output, 1, high while state is not IDLE.
REQ-016 Port done, output, 1, one-cycle pulse after the final key transfers.

Function
REQ-017 s(r) = 1 if SHIFT1_MASK[r-1] is set, else 2; C and D always rotate by the same amount and independently of each other.
REQ-018 States are IDLE and RUN, held in registers; all outputs are registered.
REQ-019 In IDLE with start=1 and abort=0: on the next edge, state becomes RUN, the mode latches, rk_round becomes 1, rk_valid becomes 1, and rk_out is loaded as follows.
- Encrypt: rotl(C0, s(1)), rotl(D0, s(1)).
- Decrypt: key_in unmodified.
REQ-020 Latency from start to the first valid key is 1 cycle.
REQ-021 In RUN, while rk_valid && !rk_ready, rk_out, rk_round and rk_valid hold stable.
REQ-022 On a transfer with rk_round < NROUNDS, rk_round increments and rk_out updates as follows.
- Encrypt: rotate left by s(rk_round+1).
- Decrypt: rotate right by s(NROUNDS+1-rk_round).
REQ-023 With rk_ready held high, one key transfers per cycle and there are no bubbles.
REQ-024 On a transfer with rk_round == NROUNDS: next cycle state = IDLE, rk_valid = 0, done = 1 for exactly one cycle; rk_out and rk_round keep their last value.
REQ-025 A new start is accepted in the same cycle that done is high, because state is already IDLE.
REQ-026 start while in RUN is ignored; the mode and key_in are not resampled mid-run.
REQ-027 abort=1 in RUN: next cycle state = IDLE, rk_valid = 0, done stays 0; this applies even when a transfer occurs in that same cycle.
REQ-028 start and abort both high in IDLE: abort wins and no run begins.
REQ-029 decrypt round r presents the same value as encrypt round NROUNDS+1-r whenever the sum of s(r) over all rounds equals HALF_W (true for the defaults).

Reset
REQ-030 While rst_n = 0, the block asynchronously forces the following.
- state = IDLE
- rk_out = 0, rk_round = 0
- rk_valid = 0, busy = 0, done = 0
- latched mode = encrypt
REQ-031 Reset asserted mid-run discards the run; no done pulse is produced.
REQ-032 Deassertion of rst_n is synchronised externally; the first start is honoured on the first edge after release.

Verification
REQ-033 Encrypt round 1: key_in = {28'hF0CCAAF, 28'h556678F}, start with decrypt = 0 -> next cycle rk_valid = 1, rk_round = 1, rk_out = {28'hE19955F, 28'hAACCF1E}.
REQ-034 Full encrypt run with rk_ready = 1: same key -> 16 consecutive transfers, round 16 rk_out = key_in, done pulses one cycle after round 16, busy high for exactly 16 cycles.
REQ-035 Decrypt run: same key with decrypt = 1 -> round 1 = key_in, round 2 = {28'hF866557, rotr1(28'h556678F)}, round 16 = {28'hE19955F, 28'hAACCF1E}, and every round r equals encrypt round 17-r.
REQ-036 Backpressure: rk_ready toggled randomly -> rk_out is stable while stalled, with no skipped or duplicated rounds.
REQ-037 Abort at round 7 together with rk_ready = 1 -> next cycle IDLE, rk_valid = 0, done never asserted; a following start runs cleanly from round 1.
REQ-038 Reset mid-run at round 5 -> all outputs are 0 immediately; start in RUN is ignored; start and abort together in IDLE start nothing.
